tensor_core_controller: RTL and testbench

Initiator-side companion to small_tensor_core. It accepts an 18-byte operand stream (matrix A, then matrix B, row-major) plus an operation code over a valid/ready input. It loads the core, pulses start, captures the nine result elements as the core walks its counter, and returns them as a 9-byte valid/ready output stream. It sits between the host byte interface and the tensor core instance.

---
 rtl/tensor_core_pkg.sv | 46 ++++
 rtl/tensor_core_controller_serializer.sv | 69 ++++++
 rtl/tensor_core_controller.sv | 152 +++++++++++++++
 tb/tb_tensor_core_controller.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core controller slice.
// Element/matrix typedefs, op codes, FSM states, index helpers.
package tensor_core_pkg;

    localparam int BUS_WIDTH  = 7;
    localparam int MATRIX_DIM = 3;
    localparam int NUM_ELEMS  = MATRIX_DIM * MATRIX_DIM;
    localparam int LOAD_BYTES = 2 * NUM_ELEMS;

    localparam int IDX_W = $clog2(LOAD_BYTES);
    localparam int CNT_W = $clog2(NUM_ELEMS + 1);
    localparam int RC_W  = $clog2(MATRIX_DIM);

    typedef logic signed [BUS_WIDTH:0] elem_t;
    typedef elem_t [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RC_W-1:0]  rc_t;

    typedef enum logic [1:0] {
        OP_MATMUL = 2'b00,
        OP_ADD    = 2'b01,
        OP_RELU   = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        LOAD,
        START,
        COMPUTE,
        DRAIN
    } ctrl_state_t;

    function automatic rc_t row_of(input idx_t idx);
        idx_t q;
        q = idx / idx_t'(MATRIX_DIM);
        return q[RC_W-1:0];
    endfunction

    function automatic rc_t col_of(input idx_t idx);
        idx_t r;
        r = idx % idx_t'(MATRIX_DIM);
        return r[RC_W-1:0];
    endfunction

endpackage

// File: rtl/tensor_core_controller_serializer.sv
// tensor_core_result_serializer: result buffer and valid/ready output stream.
// Ports: clk_i, rst_ni, cap_en_i/cap_idx_i/cap_data_i (capture),
//        drain_i (controller in DRAIN), out_* stream, done_o (last handshake).
// Optional: TENSOR_CORE_CTRL_CHECKSUM_EN appends an XOR checksum byte.
module tensor_core_result_serializer
    import tensor_core_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cap_en_i,
    input  cnt_t             cap_idx_i,
    input  elem_t            cap_data_i,
    input  logic             drain_i,
    input  logic             out_ready_i,
    output logic [BUS_WIDTH:0] out_data_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    output logic             done_o
);

`ifdef TENSOR_CORE_CTRL_CHECKSUM_EN
    localparam cnt_t LAST_IDX = cnt_t'(NUM_ELEMS);
`else
    localparam cnt_t LAST_IDX = cnt_t'(NUM_ELEMS - 1);
`endif

    elem_t res_q [NUM_ELEMS];
    cnt_t  out_idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                res_q[i] <= '0;
            end
        end else if (cap_en_i) begin
            res_q[cap_idx_i] <= cap_data_i;
        end
    end

    // Index only moves on a handshake, so data/last hold under stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_idx_q <= '0;
        end else if (drain_i && out_ready_i) begin
            out_idx_q <= out_last_o ? '0 : out_idx_q + cnt_t'(1);
        end
    end

`ifdef TENSOR_CORE_CTRL_CHECKSUM_EN
    elem_t csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            csum = csum ^ res_q[i];
        end
    end

    assign out_data_o = (out_idx_q == cnt_t'(NUM_ELEMS)) ? csum
                                                        : res_q[out_idx_q];
`else
    assign out_data_o = res_q[out_idx_q];
`endif

    assign out_valid_o = drain_i;
    assign out_last_o  = drain_i && (out_idx_q == LAST_IDX);
    assign done_o      = out_last_o && out_ready_i;

endmodule

// File: rtl/tensor_core_controller.sv
// Initiator-side controller for small_tensor_core: loads A/B and op from an
// 18-byte stream, starts the core, captures 9 results, streams them out.
// Ports: in_* operand stream, out_* result stream, busy, core_* to the core.
// Optional: TENSOR_CORE_CTRL_CHECKSUM_EN (checksum byte in result stream).
module tensor_core_controller
    import tensor_core_pkg::*;
(
    input  logic                 tensor_core_clock,
    input  logic                 reset_n_in,
    input  logic [BUS_WIDTH:0]   in_data,
    input  logic                 in_valid,
    input  logic [1:0]           in_op,
    output logic                 in_ready,
    output logic [BUS_WIDTH:0]   out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 core_write_enable,
    output logic                 core_reset,
    output logic                 core_start,
    output logic [1:0]           core_operation_select,
    output matrix_t              core_input1,
    output matrix_t              core_input2,
    input  matrix_t              core_output
);

    ctrl_state_t state_q, state_d;
    idx_t        load_idx_q, load_idx_d;
    cnt_t        cap_idx_q, cap_idx_d;
    matrix_t     a_q, a_d;
    matrix_t     b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic        core_reset_q;

    logic        cap_en;
    logic        drain;
    logic        done;
    idx_t        b_idx;
    idx_t        cap_full;
    elem_t       cap_data;

    always_ff @(posedge tensor_core_clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= LOAD;
            load_idx_q   <= '0;
            cap_idx_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            cap_idx_q    <= cap_idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            core_reset_q <= 1'b0;
        end
    end

    assign b_idx    = load_idx_q - idx_t'(NUM_ELEMS);
    assign cap_full = idx_t'(cap_idx_q);
    // Core presents element c only while its counter equals c.
    assign cap_data = core_output[row_of(cap_full)][col_of(cap_full)];

    always_comb begin
        state_d           = state_q;
        load_idx_d        = load_idx_q;
        cap_idx_d         = cap_idx_q;
        a_d               = a_q;
        b_d               = b_q;
        op_d              = op_q;
        in_ready          = 1'b0;
        core_start        = 1'b0;
        core_write_enable = 1'b1;
        busy              = 1'b0;
        cap_en            = 1'b0;
        drain             = 1'b0;

        unique case (state_q)
            LOAD: begin
                in_ready = !core_reset_q;
                if (in_valid && in_ready) begin
                    if (load_idx_q < idx_t'(NUM_ELEMS)) begin
                        a_d[row_of(load_idx_q)][col_of(load_idx_q)] = in_data;
                    end else begin
                        b_d[row_of(b_idx)][col_of(b_idx)] = in_data;
                    end
                    if (load_idx_q == '0) begin
                        op_d = in_op;
                    end
                    if (load_idx_q == idx_t'(LOAD_BYTES - 1)) begin
                        load_idx_d = '0;
                        state_d    = START;
                    end else begin
                        load_idx_d = load_idx_q + idx_t'(1);
                    end
                end
            end
            START: begin
                busy              = 1'b1;
                core_start        = 1'b1;
                core_write_enable = 1'b0;
                cap_idx_d         = '0;
                state_d           = COMPUTE;
            end
            COMPUTE: begin
                busy              = 1'b1;
                core_write_enable = 1'b0;
                cap_en            = 1'b1;
                if (cap_idx_q == cnt_t'(NUM_ELEMS - 1)) begin
                    cap_idx_d = '0;
                    state_d   = DRAIN;
                end else begin
                    cap_idx_d = cap_idx_q + cnt_t'(1);
                end
            end
            DRAIN: begin
                busy  = 1'b1;
                drain = 1'b1;
                if (done) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    tensor_core_result_serializer u_ser (
        .clk_i       (tensor_core_clock),
        .rst_ni      (reset_n_in),
        .cap_en_i    (cap_en),
        .cap_idx_i   (cap_idx_q),
        .cap_data_i  (cap_data),
        .drain_i     (drain),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_last_o  (out_last),
        .done_o      (done)
    );

    assign core_reset            = core_reset_q;
    assign core_operation_select = op_q;
    assign core_input1           = a_q;
    assign core_input2           = b_q;

endmodule

// File: tb/tb_tensor_core_controller.sv
// Directed testbench for tensor_core_controller with a behavioural core.
// Checks reset, matmul/add/ReLU, backpressure, latency and mid-run reset.
module tb_tensor_core_controller;
    import tensor_core_pkg::*;

`ifdef TENSOR_CORE_CTRL_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [1:0]  in_op;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        core_write_enable;
    logic        core_reset;
    logic        core_start;
    logic [1:0]  core_operation_select;
    matrix_t     core_input1;
    matrix_t     core_input2;
    matrix_t     core_output;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] ta [18];
    logic [7:0] rx_data [12];
    int  rx_cnt, hold_err, inrdy_err, first_cyc, accept_cyc;
    bit  rx_to, send_to;

    logic [3:0] cnt;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    tensor_core_controller dut (
        .tensor_core_clock     (clk),
        .reset_n_in            (rst_n),
        .in_data               (in_data),
        .in_valid              (in_valid),
        .in_op                 (in_op),
        .in_ready              (in_ready),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_last              (out_last),
        .out_ready             (out_ready),
        .busy                  (busy),
        .core_write_enable     (core_write_enable),
        .core_reset            (core_reset),
        .core_start            (core_start),
        .core_operation_select (core_operation_select),
        .core_input1           (core_input1),
        .core_input2           (core_input2),
        .core_output           (core_output)
    );

    // Behavioural core: counter parks at 9, start zeroes it, then it walks.
    always @(posedge clk) begin
        if (core_reset || core_write_enable) cnt <= 4'd9;
        else if (core_start) cnt <= 4'd0;
        else if (cnt < 4'd9) cnt <= cnt + 4'd1;
    end

    always_comb begin
        core_output = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                elem_t acc;
                acc = '0;
                case (core_operation_select)
                    2'b00: for (int k = 0; k < 3; k++)
                        acc = acc + core_input1[r][k] * core_input2[k][c];
                    2'b01: acc = core_input1[r][c] + core_input2[r][c];
                    2'b10: acc = core_input1[r][c][7] ? '0 : core_input1[r][c];
                    default: acc = '0;
                endcase
                core_output[r][c] = (cnt == 4'(r * 3 + c)) ? acc : 8'h5A;
            end
        end
    end

    task automatic send(input logic [1:0] op, input bit gap);
        bit ok;
        send_to = 0;
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_data  = ta[i];
            in_op    = (i == 0) ? op : 2'b11;
            ok = 0;
            for (int w = 0; w < 50 && !ok; w++) begin
                @(negedge clk);
                if (in_ready) ok = 1;
                @(posedge clk); #1;
            end
            if (!ok) send_to = 1;
            if (gap && i != 17) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                @(posedge clk); #1;
            end
        end
        in_valid   = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic collect(input bit bp, input bit junk);
        bit done, stalled;
        logic [7:0] pd;
        logic pl;
        logic [3:0] pat;
        pat = 4'b1001;
        rx_cnt = 0; hold_err = 0; inrdy_err = 0; rx_to = 0;
        first_cyc = -1; done = 0; stalled = 0; pd = '0; pl = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            out_ready = bp ? pat[2'(k % 4)] : 1'b1;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 8'hCC;
            end
            @(negedge clk);
            if (busy && in_ready) inrdy_err++;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stalled && (out_data !== pd || out_last !== pl)) hold_err++;
                stalled = !out_ready;
                pd = out_data;
                pl = out_last;
                if (out_ready) begin
                    if (rx_cnt < 12) rx_data[rx_cnt] = out_data;
                    rx_cnt++;
                    if (out_last) done = 1;
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (!done) rx_to = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        in_op = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            core_start !== 1'b0)
            $display("FAIL reset_outs: valid=%b last=%b busy=%b start=%b req 0000",
                     out_valid, out_last, busy, core_start);
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            core_start !== 1'b0) fails++;
        tests++;
        if (core_write_enable !== 1'b1 || core_reset !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_core: we=%b crst=%b in_ready=%b req 1 1 0",
                     core_write_enable, core_reset, in_ready);
        end
        tests++;
        if (core_input1 !== '0 || core_input2 !== '0 || core_operation_select !== 2'b00) begin
            fails++;
            $display("FAIL reset_regs: A=%h B=%h op=%b req 0",
                     core_input1, core_input2, core_operation_select);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0 || core_reset !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b crst=%b req 0 1", in_ready, core_reset);
        end
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || core_reset !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_edge: in_ready=%b crst=%b req 1 0", in_ready, core_reset);
        end
    endtask

    task automatic test_matmul();
        logic [7:0] exp [12];
        for (int i = 0; i < 9; i++) begin
            ta[i]     = (i % 4 == 0) ? 8'd1 : 8'd0;
            ta[9 + i] = 8'(i + 1);
            exp[i]    = 8'(i + 1);
        end
        exp[9] = 8'h01;
        send(2'b00, 1'b0);
        collect(1'b0, 1'b0);
        tests++;
        if (send_to || rx_to) begin
            fails++;
            $display("FAIL mm_timeout: send_to=%b rx_to=%b req 0 0", send_to, rx_to);
        end
        for (int i = 0; i < NB; i++) begin
            tests++;
            if (rx_data[i] !== exp[i]) begin
                fails++;
                $display("FAIL mm_byte%0d: got %h req %h", i, rx_data[i], exp[i]);
            end
        end
        tests++;
        if (rx_cnt !== NB) begin
            fails++;
            $display("FAIL mm_last: bytes to last=%0d req %0d", rx_cnt, NB);
        end
        tests++;
        if (first_cyc - accept_cyc !== 10) begin
            fails++;
            $display("FAIL mm_latency: edges=%0d req 10", first_cyc - accept_cyc);
        end
    endtask

    task automatic test_add();
        for (int i = 0; i < 9; i++) begin
            ta[i]     = 8'd100;
            ta[9 + i] = 8'd50;
        end
        send(2'b01, 1'b0);
        collect(1'b0, 1'b0);
        tests++;
        if (send_to || rx_to || rx_cnt !== NB) begin
            fails++;
            $display("FAIL add_count: cnt=%0d to=%b%b req %0d 00", rx_cnt, send_to, rx_to, NB);
        end
        for (int i = 0; i < NB; i++) begin
            tests++;
            if (rx_data[i] !== 8'h96) begin
                fails++;
                $display("FAIL add_byte%0d: got %h req 96", i, rx_data[i]);
            end
        end
    endtask

    task automatic test_relu();
        logic [7:0] exp [12];
        logic [7:0] src [9];
        src = '{8'hFF, 8'd2, 8'hFD, 8'd4, 8'hFB, 8'd6, 8'hF9, 8'd8, 8'hF7};
        exp = '{8'd0, 8'd2, 8'd0, 8'd4, 8'd0, 8'd6, 8'd0, 8'd8, 8'd0,
                8'h08, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) begin
            ta[i]     = src[i];
            ta[9 + i] = 8'd0;
        end
        send(2'b10, 1'b0);
        collect(1'b0, 1'b0);
        tests++;
        if (send_to || rx_to || rx_cnt !== NB) begin
            fails++;
            $display("FAIL relu_count: cnt=%0d to=%b%b req %0d 00", rx_cnt, send_to, rx_to, NB);
        end
        for (int i = 0; i < NB; i++) begin
            tests++;
            if (rx_data[i] !== exp[i]) begin
                fails++;
                $display("FAIL relu_byte%0d: got %h req %h", i, rx_data[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [12];
        logic [7:0] a [9];
        a   = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd2};
        exp = '{8'd9, 8'd12, 8'd15, 8'd4, 8'd5, 8'd6, 8'd14, 8'd16, 8'd18,
                8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) begin
            ta[i]     = a[i];
            ta[9 + i] = 8'(i + 1);
        end
        send(2'b00, 1'b1);
        collect(1'b1, 1'b1);
        tests++;
        if (send_to || rx_to || rx_cnt !== NB) begin
            fails++;
            $display("FAIL bp_count: cnt=%0d to=%b%b req %0d 00", rx_cnt, send_to, rx_to, NB);
        end
        for (int i = 0; i < NB; i++) begin
            tests++;
            if (rx_data[i] !== exp[i]) begin
                fails++;
                $display("FAIL bp_byte%0d: got %h req %h", i, rx_data[i], exp[i]);
            end
        end
        tests++;
        if (hold_err !== 0) begin
            fails++;
            $display("FAIL bp_hold: unstable stalls=%0d req 0", hold_err);
        end
        tests++;
        if (inrdy_err !== 0) begin
            fails++;
            $display("FAIL bp_in_ready: busy cycles with in_ready=%0d req 0", inrdy_err);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 9; i++) begin
            ta[i]     = (i % 4 == 0) ? 8'd1 : 8'd0;
            ta[9 + i] = 8'(i + 1);
        end
        send(2'b00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || core_reset !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_compute: valid=%b crst=%b in_ready=%b busy=%b req 0 1 0 0",
                     out_valid, core_reset, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_release: in_ready=%b req 0", in_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_edge: in_ready=%b valid=%b req 1 0", in_ready, out_valid);
        end

        send(2'b00, 1'b0);
        seen = 0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (!seen || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_drain: seen=%b valid=%b req 1 0", seen, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            ta[i]     = (i % 4 == 0) ? 8'd1 : 8'd0;
            ta[9 + i] = 8'(10 * i + 3);
        end
        send(2'b00, 1'b0);
        collect(1'b0, 1'b0);
        tests++;
        if (send_to || rx_to || rx_cnt !== NB) begin
            fails++;
            $display("FAIL rstmid_count: cnt=%0d to=%b%b req %0d 00", rx_cnt, send_to, rx_to, NB);
        end
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (rx_data[i] !== 8'(10 * i + 3)) begin
                fails++;
                $display("FAIL rstmid_byte%0d: got %h req %h", i, rx_data[i], 8'(10 * i + 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_matmul();
        test_add();
        test_relu();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
